// File: rtl/complete_retire_pkg.sv
// complete_retire_pkg: shared ROB entry type, opcode constants and size defaults
package complete_retire_pkg;
  localparam int DEPTH_DEF = 16;
  localparam int PREGS_DEF = 64;
  localparam int IW = 4;
  localparam int PW = 6;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_ALU = 7'b0110011;
  localparam logic [6:0] OP_ALUI = 7'b0010011;
  typedef struct packed {
    logic valid;
    logic done;
    logic [PW-1:0] pd;
    logic [PW-1:0] old_pd;
    logic [6:0] op;
  } rob_entry;
  function automatic logic has_dest(input logic [6:0] op);
    return op != OP_SW;
  endfunction
endpackage

// File: rtl/complete_retire_if.sv
// complete_retire_if: dispatch alloc pair, 3 FU results in; wakeup, regfile write, retire/free and rob_count out
interface complete_retire_if;
  import complete_retire_pkg::*;
  logic alloc_valid, alloc_ready;
  logic [PW-1:0] rob_p_1, rob_p_2, o_rob_p_1, o_rob_p_2;
  logic [6:0] rob_op_1, rob_op_2;
  logic [IW-1:0] rob_idx_1, rob_idx_2;
  logic result_valid_1, result_valid_2, result_valid_3;
  logic [31:0] result_1, result_2, result_3;
  logic [PW-1:0] result_dest_1, result_dest_2, result_dest_3;
  logic [IW-1:0] result_ROB_1, result_ROB_2, result_ROB_3;
  logic f_flag_1, f_flag_2, f_flag_3;
  logic [PW-1:0] dest_r_1, dest_r_2, dest_r_3;
  logic [31:0] f_data_1, f_data_2, f_data_3;
  logic rf_we_1, rf_we_2, rf_we_3;
  logic [PW-1:0] rf_waddr_1, rf_waddr_2, rf_waddr_3;
  logic [31:0] rf_wdata_1, rf_wdata_2, rf_wdata_3;
  logic retire_valid_1, retire_valid_2, free_valid_1, free_valid_2;
  logic [PW-1:0] free_preg_1, free_preg_2;
  logic [IW:0] rob_count;
  modport master (
    output alloc_valid, rob_p_1, rob_p_2, o_rob_p_1, o_rob_p_2, rob_op_1, rob_op_2,
    output result_valid_1, result_valid_2, result_valid_3, result_1, result_2, result_3,
    output result_dest_1, result_dest_2, result_dest_3, result_ROB_1, result_ROB_2, result_ROB_3,
    input alloc_ready, rob_idx_1, rob_idx_2, rob_count,
    input f_flag_1, f_flag_2, f_flag_3, dest_r_1, dest_r_2, dest_r_3, f_data_1, f_data_2, f_data_3,
    input rf_we_1, rf_we_2, rf_we_3, rf_waddr_1, rf_waddr_2, rf_waddr_3,
    input rf_wdata_1, rf_wdata_2, rf_wdata_3,
    input retire_valid_1, retire_valid_2, free_preg_1, free_preg_2, free_valid_1, free_valid_2
  );
  modport slave (
    input alloc_valid, rob_p_1, rob_p_2, o_rob_p_1, o_rob_p_2, rob_op_1, rob_op_2,
    input result_valid_1, result_valid_2, result_valid_3, result_1, result_2, result_3,
    input result_dest_1, result_dest_2, result_dest_3, result_ROB_1, result_ROB_2, result_ROB_3,
    output alloc_ready, rob_idx_1, rob_idx_2, rob_count,
    output f_flag_1, f_flag_2, f_flag_3, dest_r_1, dest_r_2, dest_r_3, f_data_1, f_data_2, f_data_3,
    output rf_we_1, rf_we_2, rf_we_3, rf_waddr_1, rf_waddr_2, rf_waddr_3,
    output rf_wdata_1, rf_wdata_2, rf_wdata_3,
    output retire_valid_1, retire_valid_2, free_preg_1, free_preg_2, free_valid_1, free_valid_2
  );
endinterface

// File: rtl/complete_retire.sv
// complete_retire: 16-entry ROB; clk, async rst_n, bus (slave) carries pair alloc, 3 completions, wakeup/rf write, 2-wide in-order retire
module complete_retire
  import complete_retire_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int PREGS = PREGS_DEF
) (
  input logic clk,
  input logic rst_n,
  complete_retire_if.slave bus
);
  rob_entry rob [DEPTH];
  logic [IW-1:0] head, tail, h1, t1;
  logic [IW:0] count;
  logic acc, ret1, ret2;
  logic [1:0] ret_n, rt_q, fv_q;
  logic [2:0] rv, hit, fwd, ff_q;
  logic [IW-1:0] rr [3];
  logic [PW-1:0] rd [3], fd_q [3], fp_q [2];
  logic [31:0] rdat [3], fdat_q [3];
  if (DEPTH != DEPTH_DEF || PREGS != PREGS_DEF) begin : g_size
    $error("complete_retire: index and register widths are fixed for DEPTH=16, PREGS=64");
  end
  assign rv = {bus.result_valid_3, bus.result_valid_2, bus.result_valid_1};
  assign rr = '{bus.result_ROB_1, bus.result_ROB_2, bus.result_ROB_3};
  assign rd = '{bus.result_dest_1, bus.result_dest_2, bus.result_dest_3};
  assign rdat = '{bus.result_1, bus.result_2, bus.result_3};
  for (genvar j = 0; j < 3; j++) begin : g_res
    assign hit[j] = rv[j] && rob[rr[j]].valid;
    assign fwd[j] = hit[j] && has_dest(rob[rr[j]].op);
  end
  assign h1 = head + 1'b1;
  assign t1 = tail + 1'b1;
  // retire uses registered done bits only, so a completion needs one full cycle before it can retire
  assign ret1 = rob[head].valid && rob[head].done;
  assign ret2 = ret1 && rob[h1].valid && rob[h1].done;
  assign ret_n = {1'b0, ret1} + {1'b0, ret2};
  assign bus.alloc_ready = count <= (IW+1)'(DEPTH - 2);
  assign acc = bus.alloc_valid && bus.alloc_ready;
  assign bus.rob_idx_1 = tail;
  assign bus.rob_idx_2 = t1;
  assign bus.rob_count = count;
  assign {bus.f_flag_3, bus.f_flag_2, bus.f_flag_1} = ff_q;
  assign {bus.rf_we_3, bus.rf_we_2, bus.rf_we_1} = ff_q;
  assign {bus.dest_r_1, bus.dest_r_2, bus.dest_r_3} = {fd_q[0], fd_q[1], fd_q[2]};
  assign {bus.rf_waddr_1, bus.rf_waddr_2, bus.rf_waddr_3} = {fd_q[0], fd_q[1], fd_q[2]};
  assign {bus.f_data_1, bus.f_data_2, bus.f_data_3} = {fdat_q[0], fdat_q[1], fdat_q[2]};
  assign {bus.rf_wdata_1, bus.rf_wdata_2, bus.rf_wdata_3} = {fdat_q[0], fdat_q[1], fdat_q[2]};
  assign {bus.retire_valid_2, bus.retire_valid_1} = rt_q;
  assign {bus.free_valid_2, bus.free_valid_1} = fv_q;
  assign {bus.free_preg_1, bus.free_preg_2} = {fp_q[0], fp_q[1]};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) rob[i] <= '0;
      ff_q <= '0;
      fd_q <= '{default: '0};
      fdat_q <= '{default: '0};
      rt_q <= '0;
      fv_q <= '0;
      fp_q <= '{default: '0};
    end else begin
      for (int j = 0; j < 3; j++) if (hit[j]) rob[rr[j]].done <= 1'b1;
      if (acc) begin
        rob[tail] <= '{1'b1, 1'b0, bus.rob_p_1, bus.o_rob_p_1, bus.rob_op_1};
        rob[t1] <= '{1'b1, 1'b0, bus.rob_p_2, bus.o_rob_p_2, bus.rob_op_2};
      end
      if (ret1) begin
        rob[head].valid <= 1'b0;
        rob[head].done <= 1'b0;
      end
      if (ret2) begin
        rob[h1].valid <= 1'b0;
        rob[h1].done <= 1'b0;
      end
      head <= head + IW'(ret_n);
      tail <= acc ? t1 + 1'b1 : tail;
      count <= count + (acc ? (IW+1)'(2) : (IW+1)'(0)) - (IW+1)'(ret_n);
      ff_q <= fwd;
      fd_q <= rd;
      fdat_q <= rdat;
      rt_q <= {ret2, ret1};
      fv_q <= {ret2 && has_dest(rob[h1].op), ret1 && has_dest(rob[head].op)};
      fp_q <= '{rob[head].old_pd, rob[h1].old_pd};
    end
  end
endmodule

// File: tb/tb_complete_retire.sv
// tb_complete_retire: random and directed stimulus against a queue-based ROB model with a decoupled scoreboard monitor
module tb_complete_retire;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  complete_retire_if bus();
  complete_retire #(.DEPTH(16), .PREGS(64)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  localparam logic [6:0] SW = 7'b0100011, LW = 7'b0000011, ALU = 7'b0110011, ALUI = 7'b0010011;
  typedef struct {logic [3:0] idx; logic [5:0] old; logic [6:0] op; bit done;} ment_t;
  typedef struct {int j; logic [5:0] dest; logic [31:0] data; int stamp;} fexp_t;
  typedef struct {int k; logic [5:0] old; bit fv; int stamp;} rexp_t;
  ment_t mq[$];
  fexp_t fq[$];
  rexp_t rq[$];
  int mtail, cyc, checks, errors;
  logic [2:0] rv_in;
  logic [3:0] rrob_in [3];
  logic [5:0] rdest_in [3];
  logic [31:0] rdata_in [3];
  logic [2:0] ffl, rwe;
  logic [1:0] rtv, frv;
  logic [5:0] dst [3], wad [3], fpr [2];
  logic [31:0] fdt [3], wdt [3];
  assign {bus.result_valid_3, bus.result_valid_2, bus.result_valid_1} = rv_in;
  assign {bus.result_ROB_1, bus.result_ROB_2, bus.result_ROB_3} = {rrob_in[0], rrob_in[1], rrob_in[2]};
  assign {bus.result_dest_1, bus.result_dest_2, bus.result_dest_3} = {rdest_in[0], rdest_in[1], rdest_in[2]};
  assign {bus.result_1, bus.result_2, bus.result_3} = {rdata_in[0], rdata_in[1], rdata_in[2]};
  assign ffl = {bus.f_flag_3, bus.f_flag_2, bus.f_flag_1};
  assign rwe = {bus.rf_we_3, bus.rf_we_2, bus.rf_we_1};
  assign rtv = {bus.retire_valid_2, bus.retire_valid_1};
  assign frv = {bus.free_valid_2, bus.free_valid_1};
  assign dst = '{bus.dest_r_1, bus.dest_r_2, bus.dest_r_3};
  assign wad = '{bus.rf_waddr_1, bus.rf_waddr_2, bus.rf_waddr_3};
  assign fdt = '{bus.f_data_1, bus.f_data_2, bus.f_data_3};
  assign wdt = '{bus.rf_wdata_1, bus.rf_wdata_2, bus.rf_wdata_3};
  assign fpr = '{bus.free_preg_1, bus.free_preg_2};
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  // scoreboard monitor: every pulse must match an expectation stamped for this cycle
  always @(negedge clk) begin
    int h;
    if (rst_n) begin
      for (int j = 0; j < 3; j++) if (ffl[j] || rwe[j]) begin
        h = -1;
        foreach (fq[i]) if (fq[i].j == j && fq[i].stamp == cyc) h = i;
        if (h < 0) chk($sformatf("fwd%0d_unexpected", j + 1), {ffl[j], rwe[j]}, 0);
        else begin
          chk($sformatf("f_flag_%0d", j + 1), ffl[j], 1);
          chk($sformatf("rf_we_%0d", j + 1), rwe[j], 1);
          chk($sformatf("dest_r_%0d", j + 1), dst[j], fq[h].dest);
          chk($sformatf("f_data_%0d", j + 1), fdt[j], fq[h].data);
          chk($sformatf("rf_waddr_%0d", j + 1), wad[j], fq[h].dest);
          chk($sformatf("rf_wdata_%0d", j + 1), wdt[j], fq[h].data);
          fq.delete(h);
        end
      end
      for (int i = fq.size() - 1; i >= 0; i--) if (fq[i].stamp <= cyc) begin
        chk($sformatf("fwd%0d_missing", fq[i].j + 1), ffl[fq[i].j], 1);
        fq.delete(i);
      end
      for (int k = 0; k < 2; k++) if (rtv[k]) begin
        h = -1;
        foreach (rq[i]) if (rq[i].k == k + 1 && rq[i].stamp == cyc) h = i;
        if (h < 0) chk($sformatf("retire%0d_unexpected", k + 1), rtv[k], 0);
        else begin
          chk($sformatf("free_preg_%0d", k + 1), fpr[k], rq[h].old);
          chk($sformatf("free_valid_%0d", k + 1), frv[k], rq[h].fv);
          rq.delete(h);
        end
      end
      for (int i = rq.size() - 1; i >= 0; i--) if (rq[i].stamp <= cyc) begin
        chk($sformatf("retire%0d_missing", rq[i].k), rtv[rq[i].k - 1], 1);
        rq.delete(i);
      end
    end
  end

  // reference model: ROB as an ordered queue; retire from the front using done state of earlier cycles
  task automatic pre();
    bit ok;
    int n;
    ok = bus.alloc_valid && mq.size() <= 14;
    chk("rob_count", bus.rob_count, mq.size());
    chk("alloc_ready", bus.alloc_ready, mq.size() <= 14);
    if (ok) begin
      chk("rob_idx_1", bus.rob_idx_1, mtail);
      chk("rob_idx_2", bus.rob_idx_2, (mtail + 1) % 16);
    end
    n = 0;
    if (mq.size() > 0 && mq[0].done) n = 1;
    if (n == 1 && mq.size() > 1 && mq[1].done) n = 2;
    for (int k = 0; k < n; k++) begin
      rq.push_back('{k + 1, mq[0].old, mq[0].op != SW, cyc + 1});
      void'(mq.pop_front());
    end
    for (int j = 0; j < 3; j++) if (rv_in[j])
      foreach (mq[i]) if (mq[i].idx == rrob_in[j]) begin
        mq[i].done = 1;
        if (mq[i].op != SW) fq.push_back('{j, rdest_in[j], rdata_in[j], cyc + 1});
      end
    if (ok) begin
      mq.push_back('{4'(mtail), bus.o_rob_p_1, bus.rob_op_1, 0});
      mq.push_back('{4'((mtail + 1) % 16), bus.o_rob_p_2, bus.rob_op_2, 0});
      mtail = (mtail + 2) % 16;
    end
  endtask

  task automatic tick();
    pre();
    @(negedge clk);
    bus.alloc_valid = 0;
    rv_in = '0;
  endtask

  task automatic clear_model();
    mq.delete();
    fq.delete();
    rq.delete();
    mtail = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    clear_model();
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic set_alloc(input logic [5:0] p1, p2, o1, o2, input logic [6:0] op1, op2);
    bus.alloc_valid = 1;
    bus.rob_p_1 = p1;
    bus.rob_p_2 = p2;
    bus.o_rob_p_1 = o1;
    bus.o_rob_p_2 = o2;
    bus.rob_op_1 = op1;
    bus.rob_op_2 = op2;
  endtask

  function automatic logic [6:0] rand_op();
    int r = $urandom_range(0, 3);
    return r == 0 ? SW : r == 1 ? LW : r == 2 ? ALU : ALUI;
  endfunction

  task automatic rand_alloc(input logic [6:0] op1, op2);
    set_alloc(6'($urandom), 6'($urandom), 6'($urandom), 6'($urandom), op1, op2);
  endtask

  task automatic set_res(input int j, input logic [3:0] rob, input logic [5:0] dest, input logic [31:0] data);
    rv_in[j] = 1;
    rrob_in[j] = rob;
    rdest_in[j] = dest;
    rdata_in[j] = data;
  endtask

  task automatic rand_results(input bit dense);
    int cand[$];
    int k, idx;
    bit used;
    foreach (mq[i]) if (!mq[i].done) cand.push_back(i);
    for (int j = 0; j < 3; j++) begin
      if ((dense || $urandom_range(0, 2) == 0) && cand.size() > 0) begin
        k = $urandom_range(0, cand.size() - 1);
        set_res(j, mq[cand[k]].idx, 6'($urandom), $urandom);
        cand.delete(k);
      end else if (!dense && mq.size() < 16 && $urandom_range(0, 5) == 0) begin
        idx = $urandom_range(0, 15);
        used = 0;
        foreach (mq[i]) if (mq[i].idx == 4'(idx)) used = 1;
        if (!used) set_res(j, 4'(idx), 6'($urandom), $urandom);
      end
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((mq.size() > 0 || fq.size() > 0 || rq.size() > 0) && t < 200) begin
      rand_results(1);
      tick();
      t++;
    end
    if (t >= 200) chk("drain_timeout", bus.rob_count, 0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: cycle %0d reached without finishing", cyc);
    $fatal(1);
  end

  initial begin
    bus.alloc_valid = 0;
    set_alloc(0, 0, 0, 0, 0, 0);
    bus.alloc_valid = 0;
    rv_in = '0;
    for (int j = 0; j < 3; j++) begin
      rrob_in[j] = '0;
      rdest_in[j] = '0;
      rdata_in[j] = '0;
    end
    clear_model();
    #2;
    chk("reset_rob_count", bus.rob_count, 0);
    chk("reset_alloc_ready", bus.alloc_ready, 1);
    chk("reset_pulses", {ffl, rwe, rtv, frv}, 0);
    do_reset();
    // pair allocation from reset, then out-of-order completion and paired retire
    set_alloc(10, 11, 2, 3, ALU, ALU);
    chk("first_rob_idx_1", bus.rob_idx_1, 0);
    chk("first_rob_idx_2", bus.rob_idx_2, 1);
    tick();
    chk("first_rob_count", bus.rob_count, 2);
    set_res(0, 1, 11, 32'h1111);
    tick();
    tick();
    chk("no_retire_head_pending", rtv, 0);
    set_res(1, 0, 10, 32'h1010);
    tick();
    tick();
    tick();
    chk("pair_retired_count", bus.rob_count, 0);
    // fill to 16 entries and try a 9th allocation
    for (int i = 0; i < 8; i++) begin
      rand_alloc(rand_op(), rand_op());
      tick();
    end
    chk("full_alloc_ready", bus.alloc_ready, 0);
    rand_alloc(ALU, ALU);
    tick();
    tick();
    chk("full_count_held", bus.rob_count, 16);
    drain();
    // three simultaneous completions to entries 4/5/6
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_alloc(6'(20 + 2 * i), 6'(21 + 2 * i), 6'(2 * i), 6'(2 * i + 1), ALU, i == 3 ? SW : LW);
      tick();
    end
    set_res(0, 4, 24, 7);
    set_res(1, 5, 25, 8);
    set_res(2, 6, 26, 9);
    tick();
    set_res(0, 7, 27, 32'hdead);
    tick();
    drain();
    // walk head to 15 so entries 15 and 0 retire together
    do_reset();
    for (int i = 0; i < 7; i++) begin
      rand_alloc(ALU, ALUI);
      tick();
      set_res(0, 4'(2 * i), 1, 1);
      set_res(1, 4'(2 * i + 1), 2, 2);
      tick();
      tick();
      tick();
    end
    set_alloc(30, 31, 40, 41, ALU, ALU);
    tick();
    set_res(0, 14, 30, 3);
    tick();
    tick();
    tick();
    chk("head15_count", bus.rob_count, 1);
    set_alloc(32, 33, 46, 47, ALU, ALU);
    tick();
    set_res(0, 15, 31, 4);
    set_res(1, 0, 32, 5);
    tick();
    tick();
    tick();
    chk("wrap_count", bus.rob_count, 1);
    set_res(2, 1, 33, 6);
    tick();
    tick();
    tick();
    chk("wrap_head1_count", bus.rob_count, 0);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) != 0) rand_alloc(rand_op(), rand_op());
      rand_results(0);
      tick();
    end
    drain();
    // reset with 6 entries held and forward/retire pulses in flight
    do_reset();
    for (int i = 0; i < 3; i++) begin
      rand_alloc(ALU, LW);
      tick();
    end
    set_res(0, 0, 5, 55);
    tick();
    chk("held_count", bus.rob_count, 6);
    set_res(1, 2, 6, 66);
    pre();
    @(posedge clk);
    #1;
    chk("pending_before_reset", {ffl[1], rtv[0]}, 2'b11);
    rst_n = 0;
    clear_model();
    #1;
    chk("async_rob_count", bus.rob_count, 0);
    chk("async_alloc_ready", bus.alloc_ready, 1);
    chk("async_pulses", {ffl, rwe, rtv, frv}, 0);
    chk("async_data", {bus.f_data_2, bus.dest_r_2, bus.free_preg_1}, 0);
    bus.alloc_valid = 0;
    rv_in = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_reset_quiet", {ffl, rtv}, 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/complete_retire.md
COMPLETE_RETIRE -- requirements
Module: complete_retire

Interface
REQ-001 SHALL have parameter DEPTH, default 16, giving the number of reorder-buffer entries, indexed with 4 bits.
REQ-002 SHALL have parameter PREGS, default 64, giving the physical register count, addressed with 6 bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, all state updated on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port alloc_valid, input, 1 bit: dispatch presents a pair of instructions this cycle.
REQ-006 SHALL have port alloc_ready, output, 1 bit: at least 2 entries are free.
REQ-007 SHALL have ports rob_p_k (k=1,2), input, 6 bits each: new destination physical register.
REQ-008 SHALL have ports rob_op_k, input, 7 bits each: opcode.
REQ-009 SHALL have ports o_rob_p_k, input, 6 bits each: previous mapping of the destination, freed at retire.
REQ-010 SHALL have ports rob_idx_k, output, 4 bits each: entry index assigned to slot k, valid combinationally with alloc_ready.
REQ-011 SHALL have ports result_valid_j (j=1..3), input, 1 bit each: functional unit j completed.
REQ-012 SHALL have ports result_j, input, 32 bits each; result_dest_j, input, 6 bits each; result_ROB_j, input, 4 bits each.
REQ-013 SHALL have ports f_flag_j, output, 1 bit each; dest_r_j, output, 6 bits each; f_data_j, output, 32 bits each: wakeup/forward back to dispatch.
REQ-014 SHALL have ports rf_we_j, output, 1 bit each; rf_waddr_j, output, 6 bits each; rf_wdata_j, output, 32 bits each: physical register file write.
REQ-015 SHALL have ports retire_valid_k (k=1,2), output, 1 bit each; free_preg_k, output, 6 bits each; free_valid_k, output, 1 bit each.
REQ-016 SHALL have port rob_count, output, 5 bits: occupied entries, range 0..16.

Function
REQ-017 SHALL accept an allocation only when alloc_valid and alloc_ready are both high; slot 1 is written at tail and slot 2 at tail+1, and tail advances by 2 modulo 16.
REQ-018 SHALL drive alloc_ready high only when rob_count is 14 or less; an allocation while alloc_ready is low SHALL change no state.
REQ-019 SHALL store per entry: valid, done, pd, old_pd, opcode.
REQ-020 SHALL, for each result_valid_j high with result_ROB_j pointing at a valid entry, set that entry's done bit at the next edge.
REQ-021 SHALL ignore results aimed at an invalid entry.
REQ-022 SHALL let up to 3 completions to distinct entries occur in the same cycle.
REQ-023 SHALL register f_flag_j/dest_r_j/f_data_j and rf_we_j/rf_waddr_j/rf_wdata_j from result_valid_j/result_dest_j/result_j with 1-cycle latency, for opcodes with a destination.
REQ-024 SHALL leave f_flag_j and rf_we_j low for SW (0100011) results; these pulse for exactly one cycle per completion.
REQ-025 SHALL retire in order: if the head entry is valid and done, retire it; if head+1 is also valid and done, retire both in the same cycle.
REQ-026 SHALL never retire head+1 without head.
REQ-027 SHALL register retire outputs: retire_valid_k high the cycle after retirement, with free_preg_k = old_pd and free_valid_k = 1 except for SW entries.
REQ-028 SHALL, on retirement, clear the entry's valid and done bits and advance head by the retire count modulo 16.
REQ-029 SHALL take the retire decision from the registered done bits, so a completion arriving in cycle N can retire no earlier than the edge ending cycle N+1.
REQ-030 SHALL, when allocation and retirement happen in the same cycle, update rob_count by +2 minus the retire count.
REQ-031 SHALL make head and tail wrap from 15 to 0 with no gap entry; full and empty are distinguished by rob_count, not by pointer equality.

Reset
REQ-032 SHALL, while rst_n is low, immediately force head=0, tail=0, rob_count=0, all valid/done=0, and all outputs to 0 except alloc_ready=1.
REQ-033 SHALL, on reset assertion mid-operation, discard all in-flight entries and pending forward and retire pulses; no output pulse SHALL appear in the first cycle after deassertion.

Structure
REQ-034 SHALL place the rob_entry typedef, opcode constants (OP_SW, OP_LW, OP_ALU, OP_ALUI), and DEPTH/PREGS defaults in shared package p.
REQ-035 SHALL be a single module; no sub-module is natural, and the retire selection stays inline.

Verification
REQ-036 SHALL cover: after reset, allocate pd=10/11, old=2/3 -> rob_idx 0/1, rob_count=2.
REQ-037 SHALL cover: complete ROB 1 then ROB 0 -> no retire until ROB 0 is done, then both retire in the same cycle with free_preg 2/3.
REQ-038 SHALL cover: 8 allocations with no completions -> rob_count=16, alloc_ready=0, and a 9th alloc_valid changes nothing.
REQ-039 SHALL cover: three simultaneous results to ROB 4/5/6 with data 7/8/9 -> f_flag_1..3 pulse once next cycle, dest_r and f_data match.
REQ-040 SHALL cover: head at 15 -> entries 15 and 0 retire together, head becomes 1.
REQ-041 SHALL cover: rst_n low mid-stream with 6 entries held -> outputs 0 at once, rob_count=0, no retire pulse after release.
